memch_sequencer: RTL and testbench

Controller for the three-channel memory block (MEMORIES_CHANNEL). It accepts an input pixel stream over a valid/ready handshake and loads IMAGE_SIZE pixels into each of the three channel memories in order. It then replays all three memories in parallel on request, with stall support. It generates the memory block's start, select-enable, new-channel, output-routine and read-enable controls, and sits between the host/DMA stream and the convolution datapath.

---
 rtl/memch_sequencer_if.sv | 54 +++++
 rtl/memch_sequencer.sv | 143 ++++++++++++++
 tb/tb_memch_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memch_sequencer_if.sv
// -----------------------------------------------------------------------------
// memch_sequencer_if
// Bundles the host/DMA stream side, the readout control and the memory-block
// control outputs of memch_sequencer.
//   slave  : the sequencer's view (stream/control in, memory controls out)
//   master : the environment's view (drives the stream and the start pulses)
// Signals:
//   Load_Start/Read_Start  single-cycle start pulses
//   In_Valid/In_Data/In_Ready  pixel stream handshake
//   Read_Stall  downstream back-pressure on the readout
//   Mc_*  controls and write data for the three-channel memory block
//   Read_Valid/Channel/Load_Done/Read_Done/Busy  status
// -----------------------------------------------------------------------------
interface memch_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  MEMCH_SEQ_Load_Start;
    logic                  MEMCH_SEQ_In_Valid;
    logic [DATA_WIDTH-1:0] MEMCH_SEQ_In_Data;
    logic                  MEMCH_SEQ_In_Ready;
    logic                  MEMCH_SEQ_Read_Start;
    logic                  MEMCH_SEQ_Read_Stall;
    logic                  MEMCH_SEQ_Mc_Start;
    logic                  MEMCH_SEQ_Mc_Select_En;
    logic                  MEMCH_SEQ_Mc_New_Channel_Flag;
    logic                  MEMCH_SEQ_Mc_In_Output_Rutine;
    logic                  MEMCH_SEQ_Mc_Re;
    logic [DATA_WIDTH-1:0] MEMCH_SEQ_Mc_Data;
    logic                  MEMCH_SEQ_Read_Valid;
    logic [1:0]            MEMCH_SEQ_Channel;
    logic                  MEMCH_SEQ_Load_Done;
    logic                  MEMCH_SEQ_Read_Done;
    logic                  MEMCH_SEQ_Busy;

    modport slave (
        input  MEMCH_SEQ_Load_Start, MEMCH_SEQ_In_Valid, MEMCH_SEQ_In_Data,
               MEMCH_SEQ_Read_Start, MEMCH_SEQ_Read_Stall,
        output MEMCH_SEQ_In_Ready, MEMCH_SEQ_Mc_Start, MEMCH_SEQ_Mc_Select_En,
               MEMCH_SEQ_Mc_New_Channel_Flag, MEMCH_SEQ_Mc_In_Output_Rutine,
               MEMCH_SEQ_Mc_Re, MEMCH_SEQ_Mc_Data, MEMCH_SEQ_Read_Valid,
               MEMCH_SEQ_Channel, MEMCH_SEQ_Load_Done, MEMCH_SEQ_Read_Done,
               MEMCH_SEQ_Busy
    );

    modport master (
        output MEMCH_SEQ_Load_Start, MEMCH_SEQ_In_Valid, MEMCH_SEQ_In_Data,
               MEMCH_SEQ_Read_Start, MEMCH_SEQ_Read_Stall,
        input  MEMCH_SEQ_In_Ready, MEMCH_SEQ_Mc_Start, MEMCH_SEQ_Mc_Select_En,
               MEMCH_SEQ_Mc_New_Channel_Flag, MEMCH_SEQ_Mc_In_Output_Rutine,
               MEMCH_SEQ_Mc_Re, MEMCH_SEQ_Mc_Data, MEMCH_SEQ_Read_Valid,
               MEMCH_SEQ_Channel, MEMCH_SEQ_Load_Done, MEMCH_SEQ_Read_Done,
               MEMCH_SEQ_Busy
    );
endinterface

// File: rtl/memch_sequencer.sv
// -----------------------------------------------------------------------------
// memch_sequencer
// Loads IMAGE_SIZE pixels into each of the three channel memories in turn from
// a valid/ready stream, then replays all three in parallel with stall support.
// Ports:
//   MEMCH_SEQ_Clk    clock, rising edge
//   MEMCH_SEQ_Reset  synchronous, active-low reset
//   bus              memch_sequencer_if.slave (stream, start pulses, memory
//                    controls, status)
// Mc_Select_En, Mc_Data and Mc_Re are combinational (they follow In_Valid and
// Read_Stall in the same cycle); every other output is registered.
// -----------------------------------------------------------------------------
module memch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int IMAGE_SIZE = 65536,
    parameter int CNT_WIDTH  = 17
) (
    input logic               MEMCH_SEQ_Clk,
    input logic               MEMCH_SEQ_Reset,
    memch_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_START, S_LOAD, S_LD_NEXT,
        S_LOADED, S_RD_START, S_READ, S_RD_DRAIN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(IMAGE_SIZE - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] pix_q, pix_d;
    logic [CNT_WIDTH-1:0] rd_q, rd_d;
    logic [1:0]           chan_q, chan_d;

    logic in_ready_q, mc_start_q, nc_flag_q, rutine_q;
    logic rvalid_q, ld_done_q, rd_done_q, busy_q;

    logic beat, re;

    // in_ready_q is high exactly while in LOAD
    assign beat = in_ready_q & bus.MEMCH_SEQ_In_Valid;
    assign re   = (state_q == S_READ) & ~bus.MEMCH_SEQ_Read_Stall;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        rd_d    = rd_q;
        chan_d  = chan_q;
        case (state_q)
            S_IDLE: begin
                if (bus.MEMCH_SEQ_Load_Start) begin
                    state_d = S_LD_START;
                    pix_d   = '0;
                    chan_d  = '0;
                end
            end
            S_LD_START: state_d = S_LOAD;
            S_LOAD: begin
                if (beat) begin
                    if (pix_q == LAST) begin
                        pix_d   = '0;
                        state_d = (chan_q == 2'd2) ? S_LOADED : S_LD_NEXT;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
            end
            S_LD_NEXT: begin
                state_d = S_LOAD;
                chan_d  = chan_q + 2'd1;
            end
            S_LOADED: begin
                // a simultaneous read request takes priority over a reload
                if (bus.MEMCH_SEQ_Read_Start) begin
                    state_d = S_RD_START;
                    rd_d    = '0;
                end else if (bus.MEMCH_SEQ_Load_Start) begin
                    state_d = S_LD_START;
                    pix_d   = '0;
                    chan_d  = '0;
                end
            end
            S_RD_START: state_d = S_READ;
            S_READ: begin
                if (re) begin
                    if (rd_q == LAST) state_d = S_RD_DRAIN;
                    else              rd_d    = rd_q + 1'b1;
                end
            end
            S_RD_DRAIN: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    always_ff @(posedge MEMCH_SEQ_Clk) begin
        if (!MEMCH_SEQ_Reset) begin
            state_q    <= S_IDLE;
            pix_q      <= '0;
            rd_q       <= '0;
            chan_q     <= '0;
            in_ready_q <= 1'b0;
            mc_start_q <= 1'b0;
            nc_flag_q  <= 1'b0;
            rutine_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            ld_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            rd_q       <= rd_d;
            chan_q     <= chan_d;
            in_ready_q <= (state_d == S_LOAD);
            mc_start_q <= (state_d == S_LD_START);
            nc_flag_q  <= (state_d == S_LD_NEXT);
            rutine_q   <= (state_d == S_RD_START) || (state_d == S_READ) ||
                          (state_d == S_RD_DRAIN);
            // memories present read data one cycle after Re
            rvalid_q   <= re;
            ld_done_q  <= (state_q == S_LOAD) && (state_d == S_LOADED);
            rd_done_q  <= (state_d == S_RD_DRAIN);
            busy_q     <= (state_d != S_IDLE) && (state_d != S_LOADED);
        end
    end

    assign bus.MEMCH_SEQ_In_Ready             = in_ready_q;
    assign bus.MEMCH_SEQ_Mc_Start             = mc_start_q;
    assign bus.MEMCH_SEQ_Mc_Select_En         = beat;
    assign bus.MEMCH_SEQ_Mc_Data              = beat ? bus.MEMCH_SEQ_In_Data
                                                     : {DATA_WIDTH{1'b0}};
    assign bus.MEMCH_SEQ_Mc_New_Channel_Flag  = nc_flag_q;
    assign bus.MEMCH_SEQ_Mc_In_Output_Rutine  = rutine_q;
    assign bus.MEMCH_SEQ_Mc_Re                = re;
    assign bus.MEMCH_SEQ_Read_Valid           = rvalid_q;
    assign bus.MEMCH_SEQ_Channel              = chan_q;
    assign bus.MEMCH_SEQ_Load_Done            = ld_done_q;
    assign bus.MEMCH_SEQ_Read_Done            = rd_done_q;
    assign bus.MEMCH_SEQ_Busy                 = busy_q;

endmodule

// File: tb/tb_memch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_memch_sequencer
// Scoreboard bench for memch_sequencer with IMAGE_SIZE=4. Expected write beats
// (data, channel) are queued as the stream is driven and popped when the DUT
// raises Mc_Select_En. Event cycles (Mc_Start, New_Channel, Re, Read_Valid,
// Load_Done, Read_Done) are logged and compared to bench-computed cycles.
// -----------------------------------------------------------------------------
module tb_memch_sequencer;

    localparam int DW = 16;
    localparam int IS = 4;

    typedef struct packed {
        logic [1:0]    chan;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;

    memch_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    memch_sequencer #(
        .DATA_WIDTH (DW),
        .IMAGE_SIZE (IS),
        .CNT_WIDTH  (17)
    ) dut (
        .MEMCH_SEQ_Clk   (clk),
        .MEMCH_SEQ_Reset (rst_n),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_chk, n_fail, cyc;
    bit  mon_en;
    wr_t exp_q[$];
    int  start_q[$], nc_q[$], re_q[$], rv_q[$], ld_q[$], rdn_q[$];
    int  n_sel, n_rut;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_list(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_cnt"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk(tag, got[i], exp[i]);
    endtask

    function automatic logic [31:0] all_outs();
        return {4'd0, bus.MEMCH_SEQ_In_Ready, bus.MEMCH_SEQ_Mc_Start,
                bus.MEMCH_SEQ_Mc_Select_En, bus.MEMCH_SEQ_Mc_New_Channel_Flag,
                bus.MEMCH_SEQ_Mc_In_Output_Rutine, bus.MEMCH_SEQ_Mc_Re,
                bus.MEMCH_SEQ_Mc_Data, bus.MEMCH_SEQ_Read_Valid,
                bus.MEMCH_SEQ_Channel, bus.MEMCH_SEQ_Load_Done,
                bus.MEMCH_SEQ_Read_Done, bus.MEMCH_SEQ_Busy};
    endfunction

    task automatic clr_mon();
        exp_q.delete(); start_q.delete(); nc_q.delete(); re_q.delete();
        rv_q.delete(); ld_q.delete(); rdn_q.delete();
        n_sel = 0; n_rut = 0;
    endtask

    // Mid-cycle sampling of the interval that is about to end.
    task automatic sample();
        wr_t e;
        if (!mon_en) return;
        if (bus.MEMCH_SEQ_Mc_Select_En) begin
            n_sel++;
            if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_data", bus.MEMCH_SEQ_Mc_Data, e.data);
                chk("wr_chan", bus.MEMCH_SEQ_Channel, e.chan);
            end
        end else begin
            chk("data_idle", bus.MEMCH_SEQ_Mc_Data, 0);
        end
        if (bus.MEMCH_SEQ_Mc_Start)             start_q.push_back(cyc);
        if (bus.MEMCH_SEQ_Mc_New_Channel_Flag)  nc_q.push_back(cyc);
        if (bus.MEMCH_SEQ_Mc_Re)                re_q.push_back(cyc);
        if (bus.MEMCH_SEQ_Read_Valid)           rv_q.push_back(cyc);
        if (bus.MEMCH_SEQ_Load_Done)            ld_q.push_back(cyc);
        if (bus.MEMCH_SEQ_Read_Done)            rdn_q.push_back(cyc);
        if (bus.MEMCH_SEQ_Mc_In_Output_Rutine)  n_rut++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.MEMCH_SEQ_Load_Start = 1'b0;
        bus.MEMCH_SEQ_In_Valid   = 1'b0;
        bus.MEMCH_SEQ_In_Data    = '0;
        bus.MEMCH_SEQ_Read_Start = 1'b0;
        bus.MEMCH_SEQ_Read_Stall = 1'b0;
    endtask

    // Feed pixels 1..3*IS, optionally with valid toggling and a stray
    // Load_Start in the middle of the load.
    task automatic load_stream(input bit gaps, input bit poke);
        int idx;
        wr_t w;
        idx = 0;
        for (int k = 0; k < 100 && idx < 3*IS; k++) begin
            bus.MEMCH_SEQ_In_Valid   = gaps ? (k % 2 == 0) : 1'b1;
            bus.MEMCH_SEQ_In_Data    = DW'(idx + 1);
            bus.MEMCH_SEQ_Load_Start = poke && (k == 5);
            if (bus.MEMCH_SEQ_In_Valid && bus.MEMCH_SEQ_In_Ready) begin
                w.chan = 2'(idx / IS);
                w.data = DW'(idx + 1);
                exp_q.push_back(w);
                idx++;
            end
            if (k == 3) chk("busy_load", bus.MEMCH_SEQ_Busy, 1);
            tick();
        end
        idle_inputs();
        chk("load_beats", idx, 3*IS);
    endtask

    task automatic wait_load_done();
        for (int k = 0; k < 50 && ld_q.size() == 0; k++) tick();
        chk("load_done_seen", ld_q.size(), 1);
    endtask

    initial begin
        int d, r;
        int e[$];
        n_chk = 0; n_fail = 0; cyc = 0; mon_en = 0;
        n_sel = 0; n_rut = 0;
        rst_n = 1'b0;
        idle_inputs();

        // ---- reset with random inputs: every output 0 ----
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.MEMCH_SEQ_Load_Start = 1'($urandom);
            bus.MEMCH_SEQ_In_Valid   = 1'($urandom);
            bus.MEMCH_SEQ_In_Data    = DW'($urandom);
            bus.MEMCH_SEQ_Read_Start = 1'($urandom);
            bus.MEMCH_SEQ_Read_Stall = 1'($urandom);
            @(negedge clk);
            chk("rst_outs", all_outs(), 0);
            @(posedge clk); #1;
        end
        idle_inputs();
        rst_n = 1'b1;
        mon_en = 1;
        tick();

        // ---- continuous load ----
        clr_mon();
        d = cyc;
        bus.MEMCH_SEQ_Load_Start = 1'b1;
        tick();
        bus.MEMCH_SEQ_Load_Start = 1'b0;
        load_stream(0, 0);
        wait_load_done();
        tick();
        e.delete(); e.push_back(d + 1);
        chk_list("mc_start", start_q, e);
        e.delete(); e.push_back(d + 6); e.push_back(d + 11);
        chk_list("new_chan", nc_q, e);
        e.delete(); e.push_back(d + 16);
        chk_list("load_done", ld_q, e);
        chk("sel_beats", n_sel, 12);
        chk("sb_empty", exp_q.size(), 0);
        chk("busy_loaded", bus.MEMCH_SEQ_Busy, 0);

        // ---- readout, no stall ----
        clr_mon();
        r = cyc;
        bus.MEMCH_SEQ_Read_Start = 1'b1;
        tick();
        bus.MEMCH_SEQ_Read_Start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("busy_after_read", bus.MEMCH_SEQ_Busy, 0);
        e.delete(); for (int i = 2; i <= 5; i++) e.push_back(r + i);
        chk_list("re", re_q, e);
        e.delete(); for (int i = 3; i <= 6; i++) e.push_back(r + i);
        chk_list("rvalid", rv_q, e);
        e.delete(); e.push_back(r + 6);
        chk_list("read_done", rdn_q, e);
        chk("rutine_cycles", n_rut, 6);

        // ---- Read_Start in IDLE (also after readout) is ignored ----
        clr_mon();
        bus.MEMCH_SEQ_Read_Start = 1'b1;
        tick();
        bus.MEMCH_SEQ_Read_Start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_rd_rutine", n_rut, 0);
        chk("idle_rd_re", re_q.size(), 0);
        chk("idle_rd_busy", bus.MEMCH_SEQ_Busy, 0);

        // ---- gapped load with stray Load_Start mid-load ----
        clr_mon();
        bus.MEMCH_SEQ_Load_Start = 1'b1;
        tick();
        bus.MEMCH_SEQ_Load_Start = 1'b0;
        load_stream(1, 1);
        wait_load_done();
        tick();
        chk("gap_mc_start", start_q.size(), 1);
        chk("gap_sel_beats", n_sel, 12);
        chk("gap_new_chan", nc_q.size(), 2);
        chk("gap_sb_empty", exp_q.size(), 0);

        // ---- Read_Start + Load_Start together, stall on READ cycles 2,3 ----
        clr_mon();
        r = cyc;
        bus.MEMCH_SEQ_Read_Start = 1'b1;
        bus.MEMCH_SEQ_Load_Start = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            bus.MEMCH_SEQ_Read_Stall = (cyc == r + 3) || (cyc == r + 4);
            tick();
        end
        idle_inputs();
        chk("conf_no_start", start_q.size(), 0);
        e.delete(); e.push_back(r + 2); e.push_back(r + 5);
        e.push_back(r + 6); e.push_back(r + 7);
        chk_list("stall_re", re_q, e);
        e.delete(); e.push_back(r + 3); e.push_back(r + 6);
        e.push_back(r + 7); e.push_back(r + 8);
        chk_list("stall_rvalid", rv_q, e);
        e.delete(); e.push_back(r + 8);
        chk_list("stall_read_done", rdn_q, e);
        chk("stall_rutine", n_rut, 8);
        chk("stall_idle_busy", bus.MEMCH_SEQ_Busy, 0);

        // ---- reset mid-load in channel 1 ----
        clr_mon();
        bus.MEMCH_SEQ_Load_Start = 1'b1;
        tick();
        bus.MEMCH_SEQ_Load_Start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            wr_t w;
            bus.MEMCH_SEQ_In_Valid = 1'b1;
            bus.MEMCH_SEQ_In_Data  = DW'(16'h100 + k);
            if (bus.MEMCH_SEQ_In_Ready) begin
                w.chan = (n_sel + exp_q.size() >= IS) ? 2'd1 : 2'd0;
                w.data = DW'(16'h100 + k);
                exp_q.push_back(w);
            end
            tick();
        end
        idle_inputs();
        chk("mid_chan", bus.MEMCH_SEQ_Channel, 1);
        chk("mid_ready", bus.MEMCH_SEQ_In_Ready, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_ready", bus.MEMCH_SEQ_In_Ready, 0);
        chk("rst_mid_chan", bus.MEMCH_SEQ_Channel, 0);
        chk("rst_mid_busy", bus.MEMCH_SEQ_Busy, 0);
        chk("rst_mid_outs", all_outs(), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", bus.MEMCH_SEQ_Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
